// File: rtl/cfu_command_initiator.sv
`default_nettype none
// ============================================================================
// Module   : cfu_command_initiator
// Brief    : Host-side master for the CFU register-command interface. Turns
//            each accepted host command into a one-cycle write/read strobe,
//            waits for the matching registered read response (bounded by
//            TIMEOUT cycles) and hands the completion back to the host.
// Revision : 1.0 - initial release
// ============================================================================
module cfu_command_initiator #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // host command channel
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_rd,
    input  logic [18:0] iv_cmd_addr,
    input  logic        i_cmd_addr_fixed,
    input  logic [31:0] iv_cmd_wdata,
    // slave strobe channel
    output logic        o_wr,
    output logic        o_rd,
    output logic [18:0] ov_addr,
    output logic        o_addr_fixed,
    output logic [31:0] ov_wdata,
    // slave response channel
    input  logic        i_rsp_wr,
    input  logic [18:0] iv_rsp_addr,
    input  logic        i_rsp_addr_fixed,
    input  logic [31:0] iv_rsp_rdata,
    // host completion channel
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] ov_rsp_rdata,
    output logic        o_rsp_timeout,
    // statistics
    output logic [15:0] ov_timeout_cnt,
    output logic [15:0] ov_drop_cnt
);

    localparam int unsigned C_TW = $clog2(TIMEOUT);
    localparam logic [C_TW-1:0] C_TIMER_LAST = C_TW'(TIMEOUT - 1);
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // control and datapath state
    logic [1:0]      state_q,       state_d;
    logic [C_TW-1:0] timer_q,       timer_d;
    logic            cmd_rd_q,      cmd_rd_d;
    logic [18:0]     cmd_addr_q,    cmd_addr_d;
    logic            cmd_fixed_q,   cmd_fixed_d;
    logic [31:0]     cmd_wdata_q,   cmd_wdata_d;
    logic [31:0]     rsp_rdata_q,   rsp_rdata_d;
    logic            rsp_tout_q,    rsp_tout_d;
    logic [15:0]     timeout_cnt_q, timeout_cnt_d;
    logic [15:0]     drop_cnt_q,    drop_cnt_d;

    // registered outputs, derived from the next state so they line up with it
    logic            cmd_ready_q,   cmd_ready_d;
    logic            wr_q,          wr_d;
    logic            rd_q,          rd_d;
    logic [18:0]     addr_q,        addr_d;
    logic            addr_fixed_q,  addr_fixed_d;
    logic [31:0]     wdata_q,       wdata_d;
    logic            rsp_valid_q,   rsp_valid_d;

    logic            w_match;

    assign w_match = i_rsp_wr &&
                     ({iv_rsp_addr, i_rsp_addr_fixed} == {cmd_addr_q, cmd_fixed_q});

    // next-state, command latch, completion capture and statistics counters
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cmd_rd_d      = cmd_rd_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_fixed_d   = cmd_fixed_q;
        cmd_wdata_d   = cmd_wdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_tout_d    = rsp_tout_q;
        timeout_cnt_d = timeout_cnt_q;
        drop_cnt_d    = drop_cnt_q;

        case (state_q)
            S_IDLE: begin
                // cmd_ready_q, not the state, gates the handshake: it is still
                // low in the first cycle after reset
                if (i_cmd_valid && cmd_ready_q) begin
                    cmd_rd_d    = i_cmd_rd;
                    cmd_addr_d  = iv_cmd_addr;
                    cmd_fixed_d = i_cmd_addr_fixed;
                    cmd_wdata_d = iv_cmd_wdata;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = cmd_rd_q ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                timer_d = timer_q + C_TW'(1);
                if (w_match) begin
                    // a match on the final timer cycle beats the timeout
                    rsp_rdata_d = iv_rsp_rdata;
                    rsp_tout_d  = 1'b0;
                    state_d     = S_RESP;
                end else begin
                    if (i_rsp_wr && (drop_cnt_q != C_CNT_MAX)) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                    if (timer_q == C_TIMER_LAST) begin
                        rsp_rdata_d = '0;
                        rsp_tout_d  = 1'b1;
                        if (timeout_cnt_q != C_CNT_MAX) begin
                            timeout_cnt_d = timeout_cnt_q + 16'd1;
                        end
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // output decode; slave-side fields are zero whenever no strobe is issued
    always_comb begin
        cmd_ready_d  = (state_d == S_IDLE);
        wr_d         = (state_d == S_ISSUE) && !cmd_rd_d;
        rd_d         = (state_d == S_ISSUE) &&  cmd_rd_d;
        addr_d       = (state_d == S_ISSUE) ? cmd_addr_d  : 19'd0;
        addr_fixed_d = (state_d == S_ISSUE) ? cmd_fixed_d : 1'b0;
        wdata_d      = (state_d == S_ISSUE) ? cmd_wdata_d : 32'd0;
        rsp_valid_d  = (state_d == S_RESP);
    end

    // state registers with synchronous reset to an all-zero idle condition
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            cmd_rd_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_fixed_q   <= 1'b0;
            cmd_wdata_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_tout_q    <= 1'b0;
            timeout_cnt_q <= '0;
            drop_cnt_q    <= '0;
            cmd_ready_q   <= 1'b0;
            wr_q          <= 1'b0;
            rd_q          <= 1'b0;
            addr_q        <= '0;
            addr_fixed_q  <= 1'b0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cmd_rd_q      <= cmd_rd_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_fixed_q   <= cmd_fixed_d;
            cmd_wdata_q   <= cmd_wdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_tout_q    <= rsp_tout_d;
            timeout_cnt_q <= timeout_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
            addr_fixed_q  <= addr_fixed_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    assign o_cmd_ready    = cmd_ready_q;
    assign o_wr           = wr_q;
    assign o_rd           = rd_q;
    assign ov_addr        = addr_q;
    assign o_addr_fixed   = addr_fixed_q;
    assign ov_wdata       = wdata_q;
    assign o_rsp_valid    = rsp_valid_q;
    assign ov_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_timeout  = rsp_tout_q;
    assign ov_timeout_cnt = timeout_cnt_q;
    assign ov_drop_cnt    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cfu_command_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfu_command_initiator
// Brief    : Directed self-checking bench for cfu_command_initiator (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cfu_command_initiator;

    localparam int unsigned C_TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_rd, cmd_fixed;
    logic [18:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        wr, rd, addr_fixed;
    logic [18:0] addr;
    logic [31:0] wdata;
    logic        rsp_wr, rsp_fixed;
    logic [18:0] rsp_addr;
    logic [31:0] rsp_rdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_data;
    logic [15:0] timeout_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;

    cfu_command_initiator #(.TIMEOUT(C_TIMEOUT)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (cmd_ready),
        .i_cmd_rd        (cmd_rd),
        .iv_cmd_addr     (cmd_addr),
        .i_cmd_addr_fixed(cmd_fixed),
        .iv_cmd_wdata    (cmd_wdata),
        .o_wr            (wr),
        .o_rd            (rd),
        .ov_addr         (addr),
        .o_addr_fixed    (addr_fixed),
        .ov_wdata        (wdata),
        .i_rsp_wr        (rsp_wr),
        .iv_rsp_addr     (rsp_addr),
        .i_rsp_addr_fixed(rsp_fixed),
        .iv_rsp_rdata    (rsp_rdata),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .ov_rsp_rdata    (rsp_data),
        .o_rsp_timeout   (rsp_timeout),
        .ov_timeout_cnt  (timeout_cnt),
        .ov_drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a command for one handshake cycle N; returns at the negedge of N+1.
    task automatic send_cmd(input logic r, input logic [18:0] a, input logic f,
                            input logic [31:0] d);
        cmd_valid = 1'b1; cmd_rd = r; cmd_addr = a; cmd_fixed = f; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_fixed = 1'b0; cmd_wdata = '0;
    endtask

    task automatic slave_rsp(input logic [18:0] a, input logic f, input logic [31:0] d);
        rsp_wr = 1'b1; rsp_addr = a; rsp_fixed = f; rsp_rdata = d;
    endtask

    task automatic slave_idle();
        rsp_wr = 1'b0; rsp_addr = '0; rsp_fixed = 1'b0; rsp_rdata = '0;
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, wr, rd, addr_fixed, rsp_valid, rsp_timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {cmd_ready, wr, rd, addr_fixed, rsp_valid, rsp_timeout});
        end
        checks++;
        if ({addr, wdata, rsp_data, timeout_cnt, drop_cnt} !== 115'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h tcnt=%h dcnt=%h expected all 0",
                     addr, wdata, rsp_data, timeout_cnt, drop_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        send_cmd(1'b0, 19'd0, 1'b1, 32'h1);
        checks++;
        if ({wr, rd, cmd_ready, rsp_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL write_strobe: wr,rd,ready,valid=%b expected 1000",
                     {wr, rd, cmd_ready, rsp_valid});
        end
        checks++;
        if ({addr, addr_fixed, wdata} !== {19'd0, 1'b1, 32'h1}) begin
            errors++;
            $display("FAIL write_fields: addr=%h fixed=%b wdata=%h expected 0/1/1",
                     addr, addr_fixed, wdata);
        end
        @(negedge clk);
        checks++;
        if ({wr, rd, cmd_ready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL write_done: wr,rd,ready,valid=%b expected 0010",
                     {wr, rd, cmd_ready, rsp_valid});
        end
        checks++;
        if ({addr, addr_fixed, wdata} !== 52'd0) begin
            errors++;
            $display("FAIL write_clear: addr=%h fixed=%b wdata=%h expected 0",
                     addr, addr_fixed, wdata);
        end
    endtask

    task automatic test_back_to_back();
        send_cmd(1'b0, 19'h5A5A5, 1'b0, 32'hDEADBEEF);
        checks++;
        if ({wr, addr, addr_fixed, wdata} !== {1'b1, 19'h5A5A5, 1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL b2b_first: wr=%b addr=%h fixed=%b wdata=%h expected 1/5a5a5/0/deadbeef",
                     wr, addr, addr_fixed, wdata);
        end
        @(negedge clk);
        send_cmd(1'b0, 19'h00123, 1'b1, 32'h0BADF00D);
        checks++;
        if ({wr, addr, addr_fixed, wdata} !== {1'b1, 19'h00123, 1'b1, 32'h0BADF00D}) begin
            errors++;
            $display("FAIL b2b_second: wr=%b addr=%h fixed=%b wdata=%h expected 1/00123/1/0badf00d",
                     wr, addr, addr_fixed, wdata);
        end
        @(negedge clk);
    endtask

    task automatic test_read();
        send_cmd(1'b1, 19'd0, 1'b1, 32'h0);
        checks++;
        if ({rd, wr, addr, addr_fixed} !== {1'b1, 1'b0, 19'd0, 1'b1}) begin
            errors++;
            $display("FAIL read_strobe: rd=%b wr=%b addr=%h fixed=%b expected 1/0/0/1",
                     rd, wr, addr, addr_fixed);
        end
        @(negedge clk);
        slave_rsp(19'd0, 1'b1, 32'h1);
        checks++;
        if ({rd, rsp_valid, cmd_ready} !== 3'b000) begin
            errors++;
            $display("FAIL read_wait: rd,valid,ready=%b expected 000", {rd, rsp_valid, cmd_ready});
        end
        @(negedge clk);
        slave_idle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_data, rsp_timeout} !== {1'b1, 32'h1, 1'b0}) begin
                errors++;
                $display("FAIL read_hold[%0d]: valid=%b rdata=%h tout=%b expected 1/1/0",
                         i, rsp_valid, rsp_data, rsp_timeout);
            end
            @(negedge clk);
        end
        accept();
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL read_accept: valid,ready=%b expected 01", {rsp_valid, cmd_ready});
        end
    endtask

    // Read with no slave response; expected_cnt is the counter after the timeout.
    task automatic run_timeout(input string name, input logic [15:0] expected_cnt);
        int early;
        early = 0;
        send_cmd(1'b1, 19'd3, 1'b0, 32'h0);
        for (int c = 2; c <= 1 + C_TIMEOUT; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL %s_early: valid seen in %0d WAIT cycles expected 0", name, early);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data, rsp_timeout, timeout_cnt} !==
            {1'b1, 32'h0, 1'b1, expected_cnt}) begin
            errors++;
            $display("FAIL %s: valid=%b rdata=%h tout=%b tcnt=%h expected 1/0/1/%h",
                     name, rsp_valid, rsp_data, rsp_timeout, timeout_cnt, expected_cnt);
        end
        accept();
    endtask

    task automatic test_timeout();
        run_timeout("timeout", 16'd1);
    endtask

    task automatic test_mismatch();
        send_cmd(1'b1, 19'd0, 1'b1, 32'h0);
        @(negedge clk);
        slave_rsp(19'd5, 1'b1, 32'h00000BAD);
        @(negedge clk);
        slave_rsp(19'd0, 1'b1, 32'h12345678);
        checks++;
        if ({rsp_valid, drop_cnt} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL mismatch_drop: valid=%b dcnt=%h expected 0/1", rsp_valid, drop_cnt);
        end
        @(negedge clk);
        slave_idle();
        checks++;
        if ({rsp_valid, rsp_data, rsp_timeout, drop_cnt, timeout_cnt} !==
            {1'b1, 32'h12345678, 1'b0, 16'd1, 16'd1}) begin
            errors++;
            $display("FAIL mismatch_match: valid=%b rdata=%h tout=%b dcnt=%h tcnt=%h expected 1/12345678/0/1/1",
                     rsp_valid, rsp_data, rsp_timeout, drop_cnt, timeout_cnt);
        end
        // stray response while in RESP, then in IDLE: both ignored
        slave_rsp(19'd6, 1'b0, 32'h1);
        accept();
        @(negedge clk);
        slave_idle();
        @(negedge clk);
        checks++;
        if ({drop_cnt, rsp_valid, cmd_ready} !== {16'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stray_ignored: dcnt=%h valid=%b ready=%b expected 1/0/1",
                     drop_cnt, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_boundary();
        send_cmd(1'b1, 19'd7, 1'b0, 32'h0);
        for (int c = 2; c <= C_TIMEOUT; c++) @(negedge clk);
        // now in cycle N+TIMEOUT; move to N+1+TIMEOUT, the last WAIT cycle
        @(negedge clk);
        slave_rsp(19'd7, 1'b0, 32'h0000CAFE);
        @(negedge clk);
        slave_idle();
        checks++;
        if ({rsp_valid, rsp_data, rsp_timeout, timeout_cnt} !==
            {1'b1, 32'h0000CAFE, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL boundary_match: valid=%b rdata=%h tout=%b tcnt=%h expected 1/cafe/0/1",
                     rsp_valid, rsp_data, rsp_timeout, timeout_cnt);
        end
        accept();
    endtask

    task automatic test_saturation();
        force dut.timeout_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.timeout_cnt_q;
        @(negedge clk);
        checks++;
        if (timeout_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_preload: tcnt=%h expected ffff", timeout_cnt);
        end
        run_timeout("sat_timeout", 16'hFFFF);
    endtask

    task automatic test_reset_mid_read();
        send_cmd(1'b1, 19'd0, 1'b1, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, wr, rd, addr_fixed, rsp_valid, rsp_timeout, addr, wdata,
             rsp_data, timeout_cnt, drop_cnt} !== 121'd0) begin
            errors++;
            $display("FAIL reset_mid_read: ready=%b wr=%b rd=%b valid=%b rdata=%h tcnt=%h dcnt=%h expected all 0",
                     cmd_ready, wr, rd, rsp_valid, rsp_data, timeout_cnt, drop_cnt);
        end
        rst = 1'b0;
        slave_rsp(19'd0, 1'b1, 32'h55);
        @(negedge clk);
        slave_idle();
        @(negedge clk);
        checks++;
        if ({drop_cnt, rsp_valid, cmd_ready} !== {16'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL late_rsp: dcnt=%h valid=%b ready=%b expected 0/0/1",
                     drop_cnt, rsp_valid, cmd_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_fixed = 1'b0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        slave_idle();
        @(negedge clk);
        test_reset();
        test_write();
        test_back_to_back();
        test_read();
        test_timeout();
        test_mismatch();
        test_boundary();
        test_saturation();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
